// File: rtl/serial_frame_receiver_if.sv
// serial_frame_receiver_if
//   Groups the serial bit stream, its strobe and the receiver's results.
//   master : drives in/shift_en, observes the results (the stream source side)
//   slave  : the receiver itself
//   Signals:
//     in        serial bit from the upstream shift register's low-order output
//     shift_en  bit strobe, high on cycles where `in` holds a new bit
//     out_byte  last correctly received word
//     done      one-cycle pulse, out_byte just updated with a good frame
//     ferr      one-cycle pulse, stop bit sampled as 0
//     perr      one-cycle pulse, parity mismatch (0 when parity is not built in)
//     busy      high whenever the receiver is not idle
interface serial_frame_receiver_if #(
  parameter int DATA_W = 8
);
  logic              in;
  logic              shift_en;
  logic [DATA_W-1:0] out_byte;
  logic              done;
  logic              ferr;
  logic              perr;
  logic              busy;

  modport master (
    output in,
    output shift_en,
    input  out_byte,
    input  done,
    input  ferr,
    input  perr,
    input  busy
  );

  modport slave (
    input  in,
    input  shift_en,
    output out_byte,
    output done,
    output ferr,
    output perr,
    output busy
  );
endinterface

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Frames the serial stream coming out of the load/shift register stage:
//   start bit (0), DATA_W data bits LSB first, optional odd-parity bit, stop
//   bit (1). Good words are presented on out_byte with a one-cycle done pulse;
//   bad stop bits raise ferr, bad parity raises perr, and the word is dropped.
//   All sampling happens only on clock edges where shift_en is high.
//
//   Build option: define SERIAL_RX_PARITY_EN to include the parity bit and
//   perr; without it frames carry no parity bit and perr is tied low.
//
//   Ports:
//     clk     rising-edge clock shared with the shift register stage
//     areset  asynchronous active-high reset
//     rx      serial_frame_receiver_if.slave (in, shift_en, out_byte, done,
//             ferr, perr, busy)
module serial_frame_receiver #(
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   areset,
  serial_frame_receiver_if.slave rx
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

`ifdef SERIAL_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
  typedef enum logic [2:0] {IDLE, DATA, STOP, WAIT_IDLE} state_t;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] out_byte_q, out_byte_d;
  logic              done_q, done_d;
  logic              ferr_q, ferr_d;
`ifdef SERIAL_RX_PARITY_EN
  logic              par_q, par_d;
  logic              perr_q, perr_d;

  // Odd parity holds when data bits plus parity bit have an odd popcount.
  function automatic logic parity_ok(input logic [DATA_W-1:0] d, input logic p);
    return ^{d, p};
  endfunction
`endif

  // ---- next-state / output decode ----
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    shreg_d    = shreg_q;
    out_byte_d = out_byte_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_d      = par_q;
    perr_d     = 1'b0;
`endif
    if (rx.shift_en) begin
      case (state_q)
        IDLE: begin
          if (!rx.in) begin
            state_d = DATA;
            count_d = '0;
          end
        end
        DATA: begin
          // Shifting in from the top lands the first (LSB) bit at bit 0
          // once all DATA_W bits are in, i.e. bit `count` gets sample `count`.
          shreg_d = {rx.in, shreg_q[DATA_W-1:1]};
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: begin
          par_d   = rx.in;
          state_d = STOP;
        end
`endif
        STOP: begin
          if (rx.in) begin
            state_d = IDLE;
`ifdef SERIAL_RX_PARITY_EN
            if (parity_ok(shreg_q, par_q)) begin
              out_byte_d = shreg_q;
              done_d     = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
`else
            out_byte_d = shreg_q;
            done_d     = 1'b1;
`endif
          end else begin
            // A bad stop bit wins over any parity problem.
            state_d = WAIT_IDLE;
            ferr_d  = 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx.in) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---- control and result registers ----
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      out_byte_q <= '0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      out_byte_q <= out_byte_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
`ifdef SERIAL_RX_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  // ---- data capture registers ----
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
`ifdef SERIAL_RX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign rx.out_byte = out_byte_q;
  assign rx.done     = done_q;
  assign rx.ferr     = ferr_q;
`ifdef SERIAL_RX_PARITY_EN
  assign rx.perr     = perr_q;
`else
  assign rx.perr     = 1'b0;
`endif
  assign rx.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver
//   Drives framed serial words into serial_frame_receiver and checks the
//   done/ferr/perr pulses, out_byte and busy against a small reference model.
module tb_serial_frame_receiver;

  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic areset;

  serial_frame_receiver_if #(.DATA_W(DATA_W)) rx ();

  serial_frame_receiver #(.DATA_W(DATA_W)) dut (
    .clk    (clk),
    .areset (areset),
    .rx     (rx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // kind: 0 = done, 1 = ferr, 2 = perr
  typedef struct {
    int                kind;
    logic [DATA_W-1:0] val;
    int                at;
  } evt_t;

  evt_t sb[$];

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              stop;
    logic              bad_par;
    int                per;
  } vec_t;

  vec_t vecs[11];

  logic [DATA_W-1:0] exp_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Pulse monitor: every pulse must match the next expected event in order,
  // at the exact cycle of the stop-bit strobe, and last one cycle only.
  logic prev_done = 1'b0;
  logic prev_ferr = 1'b0;
  logic prev_perr = 1'b0;

  always @(negedge clk) begin
    if (!areset) begin
      if (rx.done || rx.ferr || rx.perr) begin
        int kind;
        kind = rx.done ? 0 : (rx.ferr ? 1 : 2);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: kind %0d at cycle %0d, none expected", kind, cyc);
        end else begin
          evt_t e;
          e = sb.pop_front();
          check("pulse_kind", kind, e.kind);
          check("pulse_cycle", cyc, e.at);
          check("pulse_out_byte", rx.out_byte, e.val);
        end
      end
      if ((rx.done && prev_done) || (rx.ferr && prev_ferr) || (rx.perr && prev_perr)) begin
        checks++;
        errors++;
        $display("FAIL pulse_width: pulse high two cycles at cycle %0d, required one", cyc);
      end
    end
    prev_done = rx.done;
    prev_ferr = rx.ferr;
    prev_perr = rx.perr;
  end

  task automatic send_bit(input logic b, input int per);
    rx.in       = b;
    rx.shift_en = 1'b1;
    @(posedge clk);
    #1;
    rx.shift_en = 1'b0;
    for (int i = 1; i < per; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] data, input logic stop,
                            input logic bad_par, input int per);
    evt_t e;
    send_bit(1'b0, per);
    check("busy_after_start", rx.busy, 1);
    for (int i = 0; i < DATA_W; i++) begin
      send_bit(data[i], per);
    end
`ifdef SERIAL_RX_PARITY_EN
    send_bit((~^data) ^ bad_par, per);
`endif
    if (!stop) begin
      e.kind = 1;
`ifdef SERIAL_RX_PARITY_EN
    end else if (bad_par) begin
      e.kind = 2;
`endif
    end else begin
      e.kind  = 0;
      exp_out = data;
    end
    e.val = exp_out;
    e.at  = cyc + 1;
    sb.push_back(e);
    send_bit(stop, per);
    check("out_byte_after_frame", rx.out_byte, exp_out);
    check("busy_after_stop", rx.busy, stop ? 0 : 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{8'hA5, 1'b1, 1'b0, 1};
    vecs[1]  = '{8'hA5, 1'b1, 1'b1, 1};
    vecs[2]  = '{8'h3C, 1'b0, 1'b0, 1};
    vecs[3]  = '{8'h01, 1'b1, 1'b0, 1};
    vecs[4]  = '{8'h12, 1'b1, 1'b0, 3};
    vecs[5]  = '{8'h34, 1'b1, 1'b0, 3};
    vecs[6]  = '{8'h5A, 1'b1, 1'b0, 1};
    vecs[7]  = '{8'h00, 1'b1, 1'b0, 2};
    vecs[8]  = '{8'hFF, 1'b1, 1'b0, 1};
    vecs[9]  = '{8'h80, 1'b0, 1'b1, 2};
    vecs[10] = '{8'h7E, 1'b1, 1'b0, 1};

    exp_out     = '0;
    areset      = 1'b1;
    rx.in       = 1'b1;
    rx.shift_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;

    check("reset_out_byte", rx.out_byte, 0);
    check("reset_busy", rx.busy, 0);
    check("reset_done", rx.done, 0);
    check("reset_ferr", rx.ferr, 0);
    check("reset_perr", rx.perr, 0);

    // Idle line ones must not start a frame.
    send_bit(1'b1, 1);
    send_bit(1'b1, 1);
    check("idle_busy", rx.busy, 0);

    for (int v = 0; v < 11; v++) begin
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].bad_par, vecs[v].per);
      if (!vecs[v].stop) begin
        // Zeros while waiting for idle are never start bits.
        for (int k = 0; k < 3; k++) begin
          send_bit(1'b0, vecs[v].per);
          check("wait_idle_busy", rx.busy, 1);
        end
        send_bit(1'b1, vecs[v].per);
        check("wait_idle_exit_busy", rx.busy, 0);
        check("wait_idle_out_byte", rx.out_byte, exp_out);
      end
    end

    // Asynchronous reset after the 4th data bit of a 0xFF frame.
    send_bit(1'b0, 1);
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1, 1);
    end
    check("midframe_busy", rx.busy, 1);
    areset = 1'b1;
    #1;
    exp_out = '0;
    check("areset_busy", rx.busy, 0);
    check("areset_out_byte", rx.out_byte, 0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_bit(1'b1, 1);
    end
`ifdef SERIAL_RX_PARITY_EN
    send_bit(1'b1, 1);
`endif
    send_bit(1'b1, 1);
    check("after_reset_tail_busy", rx.busy, 0);
    check("after_reset_tail_out_byte", rx.out_byte, 0);

    send_frame(8'hFF, 1'b1, 1'b0, 1);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    check("final_out_byte", rx.out_byte, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
